// File: rtl/shift_add_mult16_ctrl.sv
// -----------------------------------------------------------------------------
// shift_add_mult16_ctrl
//
// Sequential 16x16 shift-add multiplier: control FSM plus datapath. It drives
// an external 5-bit iteration counter (COUNTER16) through cnt_reset (reload to
// 1) and cnt_set (increment). It uses that counter's cnt_done flag (count has
// reached 16) to end the 16 iterations.
//
// Handshakes:
//   start/busy : start is sampled only when the block can accept an operation.
//                That is in IDLE, or in DONE together with ack (back-to-back).
//                In every other cycle start is ignored and not queued.
//   valid/ack  : valid is high only in DONE. product is held stable there
//                until ack is seen, and the block leaves DONE on that edge.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous, active-high reset
//   start      in   1   request a multiply
//   a          in   16  multiplicand, sampled with start
//   b          in   16  multiplier, sampled with start
//   ack        in   1   consumer accepts product
//   busy       out  1   high in LOAD, CALC and DONE
//   valid      out  1   product valid (DONE only)
//   product    out  32  result register
//   cnt_set    out  1   counter increment (count16set)
//   cnt_reset  out  1   counter reload to 1 (count16reset)
//   cnt_done   in   1   counter reached 16 (count16done)
//
// Build option:
//   SIGNED_MULT_EN  When defined, a and b are two's complement. The magnitudes
//                   are multiplied and the result is negated on DONE entry
//                   when the operand signs differ. When undefined, arithmetic
//                   is unsigned only.
// -----------------------------------------------------------------------------
module shift_add_mult16_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 ack,
  output logic                 busy,
  output logic                 valid,
  output logic [2*WIDTH-1:0]   product,
  output logic                 cnt_set,
  output logic                 cnt_reset,
  input  logic                 cnt_done
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // The operation is accepted in the cycle where start is honoured. The
  // operand registers load on that edge.
  logic accept;

  // ---------------------------------------------------------------------------
  // Datapath registers
  //   a_reg       : multiplicand (magnitude in the signed build)
  //   p_reg       : {upper accumulator, remaining multiplier bits}. The adder
  //                 carry shifts into bit 31 each iteration, so no separate
  //                 carry flop is kept between iterations.
  //   product_reg : result, written only on DONE entry or by reset
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   a_reg;
  logic [2*WIDTH-1:0] p_reg;
  logic [2*WIDTH-1:0] product_reg;

  // ---------------------------------------------------------------------------
  // Operand conditioning
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

`ifdef SIGNED_MULT_EN
  logic sgn_reg;
  logic sgn_in;

  // Taking the magnitude of -32768 gives 0x8000. That value is still correct
  // when read as an unsigned 16-bit magnitude.
  assign a_mag  = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag  = b[WIDTH-1] ? (~b + 1'b1) : b;
  assign sgn_in = a[WIDTH-1] ^ b[WIDTH-1];
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  // ---------------------------------------------------------------------------
  // One shift-add iteration:
  //   {c, U} = P[31:16] + (P[0] ? A : 0)
  //   P     <= {c, U, P[15:1]}
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] p_iter;

  assign addend = p_reg[0] ? a_reg : '0;
  assign sum    = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign p_iter = {sum, p_reg[WIDTH-1:1]};

  // Value captured into product on DONE entry. It is taken from p_iter
  // because the 16th iteration completes on that same edge.
  logic [2*WIDTH-1:0] result;

`ifdef SIGNED_MULT_EN
  assign result = sgn_reg ? ((2*WIDTH)'(0) - p_iter) : p_iter;
`else
  assign result = p_iter;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and accept decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        // The counter is reloaded to 1 here, so CALC starts with count 1.
        state_next = S_CALC;
      end
      S_CALC: begin
        // cnt_done marks the 16th iteration, which still runs this cycle.
        if (cnt_done) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (ack) begin
          if (start) begin
            accept     = 1'b1;
            state_next = S_LOAD;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      p_reg       <= '0;
      product_reg <= '0;
`ifdef SIGNED_MULT_EN
      sgn_reg     <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_reg   <= a_mag;
        p_reg   <= {{WIDTH{1'b0}}, b_mag};
`ifdef SIGNED_MULT_EN
        sgn_reg <= sgn_in;
`endif
      end else if (state == S_CALC) begin
        p_reg <= p_iter;
      end

      if ((state == S_CALC) && cnt_done) begin
        product_reg <= result;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The counter strobes are decoded from the registered state. cnt_set is
  // further gated by cnt_done so the counter stops at 16. The strobes cannot
  // overlap because each one is tied to a single state.
  assign busy      = (state != S_IDLE);
  assign valid     = (state == S_DONE);
  assign cnt_reset = (state == S_LOAD);
  assign cnt_set   = (state == S_CALC) && !cnt_done;
  assign product   = product_reg;

endmodule

// File: tb/tb_shift_add_mult16_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_add_mult16_ctrl
//
// Bench for shift_add_mult16_ctrl. It includes a behavioural model of the
// external COUNTER16 (reload to 1, increment, done at 16). Expected products
// come from plain integer multiplication of the operands.
// -----------------------------------------------------------------------------
module tb_shift_add_mult16_ctrl;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        ack;
  logic        busy;
  logic        valid;
  logic [31:0] product;
  logic        cnt_set;
  logic        cnt_reset;
  logic        cnt_done;

  logic [4:0]  cnt_q;

  always #5 clk = ~clk;

  shift_add_mult16_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .ack       (ack),
    .busy      (busy),
    .valid     (valid),
    .product   (product),
    .cnt_set   (cnt_set),
    .cnt_reset (cnt_reset),
    .cnt_done  (cnt_done)
  );

  // Model of the downstream 5-bit iteration counter.
  always @(posedge clk) begin
    if (rst)            cnt_q <= 5'd0;
    else if (cnt_reset) cnt_q <= 5'd1;
    else if (cnt_set)   cnt_q <= cnt_q + 5'd1;
  end
  assign cnt_done = (cnt_q == 5'd16);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  function automatic logic [31:0] ref_mult(input logic [15:0] x, input logic [15:0] y);
`ifdef SIGNED_MULT_EN
    int sx;
    int sy;
    sx = $signed(x);
    sy = $signed(y);
    return 32'(sx * sy);
`else
    logic [31:0] ux;
    logic [31:0] uy;
    ux = {16'b0, x};
    uy = {16'b0, y};
    return ux * uy;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (drive and sample on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_op(input logic [15:0] x, input logic [15:0] y);
    a     = x;
    b     = y;
    start = 1'b1;
    exp_q.push_back(ref_mult(x, y));
  endtask

  // Ticks until valid is seen. start and ack are released after the first
  // edge. Counts the cycles and the counter strobes seen along the way.
  task automatic wait_valid(output int n, output int n_res, output int n_set);
    int n_both;
    n = 0; n_res = 0; n_set = 0; n_both = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        start = 1'b0;
        ack   = 1'b0;
      end
      if (cnt_reset === 1'b1) n_res++;
      if (cnt_set === 1'b1)   n_set++;
      if ((cnt_set & cnt_reset) === 1'b1) n_both++;
    end while ((valid !== 1'b1) && (n < 40));
    check("valid_seen", 32'(valid), 32'd1);
    check("strobe_excl", 32'(n_both), 32'd0);
  endtask

  task automatic check_product(input string tag, output logic [31:0] expv);
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s: observed=0x%08h expected=<empty queue>", tag, product);
      expv = 'x;
    end else begin
      expv = exp_q.pop_front();
      check(tag, product, expv);
    end
  endtask

  task automatic ack_release(input logic [31:0] expv);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(valid), 32'd0);
    check("idle_product_held", product, expv);
  endtask

  // Complete operation: start, latency and strobe checks, product check,
  // an optional ack delay with a stability check, then ack.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input int ack_delay);
    int n, nr, ns;
    logic [31:0] expv;
    start_op(x, y);
    wait_valid(n, nr, ns);
    check("latency", 32'(n), 32'd18);
    check("cnt_reset_cycles", 32'(nr), 32'd1);
    check("cnt_set_cycles", 32'(ns), 32'd15);
    check_product("product", expv);
    for (int i = 0; i < ack_delay; i++) begin
      tick();
      check("hold_valid", 32'(valid), 32'd1);
      check("hold_product", product, expv);
    end
    ack_release(expv);
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n, nr, ns;
    logic [31:0] expv;

    rst = 1'b1; start = 1'b0; ack = 1'b0; a = '0; b = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_product", product, 32'd0);
    check("rst_cnt_set", 32'(cnt_set), 32'd0);
    check("rst_cnt_reset", 32'(cnt_reset), 32'd0);

    // 3 x 5, then the corner operands.
    run_op(16'd3, 16'd5, 0);
    run_op(16'hFFFF, 16'hFFFF, 0);
    run_op(16'h1234, 16'h0000, 1);
    run_op(16'h0000, 16'hABCD, 2);

    // Hold ack low for 10 cycles while start and the operands wiggle.
    start_op(16'($urandom), 16'($urandom));
    wait_valid(n, nr, ns);
    check("hold_latency", 32'(n), 32'd18);
    check_product("hold_first", expv);
    for (int i = 0; i < 10; i++) begin
      start = 1'($urandom_range(0, 1));
      a     = 16'($urandom);
      b     = 16'($urandom);
      tick();
      check("hold10_valid", 32'(valid), 32'd1);
      check("hold10_product", product, expv);
      check("hold10_cnt_reset", 32'(cnt_reset), 32'd0);
    end
    start = 1'b0;
    ack_release(expv);

    // Back-to-back: ack and start together in DONE go straight to LOAD.
    start_op(16'd11, 16'd13);
    wait_valid(n, nr, ns);
    check_product("b2b_first", expv);
    a = 16'd7; b = 16'd9; start = 1'b1; ack = 1'b1;
    exp_q.push_back(ref_mult(16'd7, 16'd9));
    wait_valid(n, nr, ns);
    check("b2b_latency", 32'(n), 32'd18);
    check("b2b_cnt_reset", 32'(nr), 32'd1);
    check_product("b2b_second", expv);
    check("b2b_const", expv, 32'h0000003F);
    ack_release(expv);

    // Reset during the 8th CALC cycle discards the operation.
    start_op(16'($urandom), 16'($urandom));
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(exp_q.pop_front());
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_product", product, 32'd0);
    check("midrst_cnt_set", 32'(cnt_set), 32'd0);
    run_op(16'd2, 16'd2, 0);

`ifdef SIGNED_MULT_EN
    run_op(16'hFFFD, 16'd7, 0);
    run_op(16'h8000, 16'h8000, 0);
`endif

    // Random operands, random ack delay. Every fourth operation pulses start
    // in the middle of CALC, where it must be ignored.
    for (int k = 0; k < 24; k++) begin
      logic [15:0] x, y;
      x = 16'($urandom);
      y = 16'($urandom);
      if (k % 6 == 0) x = 16'hFFFF;
      if (k % 6 == 3) y = 16'h8000;
      if (k % 4 == 1) begin
        start_op(x, y);
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        start = 1'b1; a = 16'($urandom); b = 16'($urandom);
        tick();
        start = 1'b0;
        wait_valid(n, nr, ns);
        check("rnd_ignored_start_latency", 32'(n + 7), 32'd18);
        check_product("rnd_ignored_start_product", expv);
        ack_release(expv);
      end else begin
        run_op(x, y, $urandom_range(0, 3));
      end
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/shift_add_mult16_ctrl.md
Name: shift_add_mult16_ctrl

Overview:
Sequential 16x16 shift-add multiplier: control FSM plus datapath. It sits directly upstream of the 5-bit iteration counter (COUNTER16), driving that counter's set and reset inputs and consuming its done flag to terminate the 16 iterations. It accepts operands via a start/busy handshake and holds the 32-bit product under a valid/ack handshake.

Parameters:
WIDTH, 16, operand width. Fixed at 16 to match the counter's terminal count (bit 4); other values are unsupported.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a multiply; sampled only when ready to accept
a  input  16  multiplicand, sampled with start
b  input  16  multiplier, sampled with start
ack  input  1  consumer accepts product
busy  output  1  high in LOAD, CALC and DONE
valid  output  1  product valid, high only in DONE
product  output  32  result register
cnt_set  output  1  to counter count16set: increment
cnt_reset  output  1  to counter count16reset: reload to 1
cnt_done  input  1  from counter count16done: count has reached 16

Behaviour:
- Reset (rst=1 at clk edge):
  - state goes to IDLE; busy, valid, cnt_set, cnt_reset = 0; product = 0.
  - Internal A and P registers clear to 0.
  - Applies from any state, including mid-CALC; any partial result is discarded.
- States: IDLE, LOAD, CALC, DONE.
- IDLE:
  - start=1 → LOAD.
  - Latch A=a; P={16'b0, b}; clear the carry bit.
- LOAD:
  - cnt_reset=1 for exactly this one cycle; counter reads 1 at the next edge.
  - → CALC unconditionally.
- CALC:
  - One iteration per cycle: {c, U} = P[31:16] + (P[0] ? A : 0), 17-bit sum.
  - Then P ← {c, U, P[15:1]}.
  - cnt_set = ~cnt_done.
  - cnt_done=0: stay in CALC. cnt_done=1: this is the 16th iteration; → DONE.
  - Iterations run while the counter reads 1..16, so exactly 16 are performed.
- DONE:
  - valid=1; product is registered on DONE entry and held stable until it leaves DONE.
  - ack=1, start=0 → IDLE.
  - ack=1, start=1 → LOAD directly (back-to-back), latching the new a/b.
  - ack=0: stay; start is ignored.
- Latency: start sampled at edge E0 → valid high in the cycle after E17 (18 cycles). Steady-state throughput is one result per 18 cycles when ack is returned immediately.
- start while busy, outside DONE+ack: ignored and not queued.
- cnt_set and cnt_reset are mutually exclusive. Both are decoded combinationally from the registered state (glitch-free relative to clk) and are never asserted in IDLE or DONE.
- cnt_done high in any state other than CALC is ignored.
- product retains its last value in IDLE. It updates only on DONE entry or rst.
- Arithmetic: unsigned. Maximum product is 0xFFFE0001; the carry bit c guarantees no overflow.

Optional Feature:
SIGNED_MULT_EN
- Defined:
  - a and b are two's complement.
  - LOAD latches |a| and |b| and registers sgn = a[15]^b[15].
  - On DONE entry, product = sgn ? -P : P (32-bit two's complement).
  - -32768 × -32768 = 0x40000000.
- Undefined: unsigned only; the sgn register and negation logic are absent.

Test Plan:
- Reset, then a=3, b=5, start pulse:
  - cnt_reset seen for 1 cycle, then cnt_set for 15 cycles.
  - valid rises 18 cycles after start; product=0x0000000F.
  - ack → IDLE, busy=0.
- a=0xFFFF, b=0xFFFF → product=0xFFFE0001.
- a=0x1234, b=0 → product=0.
- a=0, b=0xABCD → product=0.
- Hold ack=0 for 10 cycles after valid, and toggle start/a/b meanwhile → product and valid stable, no new operation.
- DONE with ack=1 and start=1 (a=7, b=9) → next cycle in LOAD; second valid gives product=0x3F, 18 cycles later.
- rst asserted on the 8th CALC cycle → next cycle IDLE, busy=0, valid=0, product=0, cnt_set=0. A new start (a=2, b=2) then yields 4.
- SIGNED_MULT_EN only: a=0xFFFD (-3), b=7 → 0xFFFFFFEB. a=0x8000, b=0x8000 → 0x40000000.
